// File: rtl/cnn_conv_acc_relu.sv
// ---------------------------------------------------------------------------
// cnn_conv_acc_relu
// Accumulates a stream of signed conv-layer products into one output-pixel
// sum. The first beat of each group is pre-loaded with a left-shifted bias.
// The sum saturates at ACC_W bits. On the last beat the sum is requantised
// with round-half-up, passed through an optional ReLU, clamped to OUT_W bits
// and presented on a registered valid/ready output.
//
// Ports
//   ap_clk, ap_rst_n        : clock (rising edge), async active-low reset
//   prod_valid/prod_ready   : product beat handshake
//   prod_data, prod_last    : signed product, end-of-group marker
//   bias                    : signed bias, sampled on the first beat only
//   out_valid/out_ready     : result handshake
//   out_data                : signed activation
//   acc_sat                 : accumulator saturated during the presented group
//   grp_len                 : beat count of the presented group (mod 2^16)
// ---------------------------------------------------------------------------
module cnn_conv_acc_relu #(
  parameter int PROD_W     = 24,
  parameter int BIAS_W     = 14,
  parameter int ACC_W      = 32,
  parameter int OUT_W      = 14,
  parameter int SHIFT      = 8,
  parameter int BIAS_SHIFT = 8,
  parameter bit RELU_EN    = 1'b1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  input  logic [BIAS_W-1:0] bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              acc_sat,
  output logic [15:0]       grp_len
);

  // One guard bit above the accumulator is enough to detect overflow of
  // acc + product and to hold the rounding addend without wrapping.
  localparam int EW = ACC_W + 1;
  typedef logic signed [EW-1:0] ext_t;

  localparam ext_t ACC_MAX_E = {2'b00, {(ACC_W-1){1'b1}}};
  localparam ext_t ACC_MIN_E = {2'b11, {(ACC_W-1){1'b0}}};
  localparam ext_t OUT_MAX_E = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam ext_t OUT_MIN_E = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam ext_t RND_E     = {{(EW-1){1'b0}}, 1'b1} << (SHIFT-1);

  // State registers
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    first_q, first_d;
  logic [15:0]             beat_cnt_q, beat_cnt_d;
  logic                    sat_q, sat_d;
  logic                    out_valid_q, out_valid_d;
  logic [OUT_W-1:0]        out_data_q, out_data_d;
  logic                    acc_sat_q, acc_sat_d;
  logic [15:0]             grp_len_q, grp_len_d;

  // Datapath intermediates
  ext_t             prod_e_s;
  ext_t             bias_e_s;
  ext_t             base_s;
  ext_t             sum_s;
  ext_t             sum_sat_s;
  ext_t             rnd_s;
  ext_t             shr_s;
  logic             clamp_s;
  logic             accept_s;
  logic [OUT_W-1:0] act_s;

  // A full output register blocks the whole group, not only its last beat.
  assign prod_ready = !out_valid_q || out_ready;
  assign accept_s   = prod_valid && prod_ready;

  // Accumulate, saturate, requantise, ReLU and clamp the candidate result.
  always_comb begin
    prod_e_s = {{(EW-PROD_W){prod_data[PROD_W-1]}}, prod_data};
    bias_e_s = {{(EW-BIAS_W){bias[BIAS_W-1]}}, bias} << BIAS_SHIFT;

    if (first_q) begin
      base_s = bias_e_s;
    end else begin
      base_s = {acc_q[ACC_W-1], acc_q};
    end
    sum_s = base_s + prod_e_s;

    if (sum_s > ACC_MAX_E) begin
      sum_sat_s = ACC_MAX_E;
      clamp_s   = 1'b1;
    end else if (sum_s < ACC_MIN_E) begin
      sum_sat_s = ACC_MIN_E;
      clamp_s   = 1'b1;
    end else begin
      sum_sat_s = sum_s;
      clamp_s   = 1'b0;
    end

    // Adding half an output LSB before the arithmetic shift rounds half up.
    rnd_s = sum_sat_s + RND_E;
    shr_s = rnd_s >>> SHIFT;

    if (RELU_EN && shr_s[EW-1]) begin
      act_s = {OUT_W{1'b0}};
    end else if (shr_s > OUT_MAX_E) begin
      act_s = OUT_MAX_E[OUT_W-1:0];
    end else if (shr_s < OUT_MIN_E) begin
      act_s = OUT_MIN_E[OUT_W-1:0];
    end else begin
      act_s = shr_s[OUT_W-1:0];
    end
  end

  // Next-state for the group accumulator and the output register.
  always_comb begin
    acc_d       = acc_q;
    first_d     = first_q;
    beat_cnt_d  = beat_cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    acc_sat_d   = acc_sat_q;
    grp_len_d   = grp_len_q;

    if (accept_s) begin
      if (prod_last) begin
        // Close the group: publish the result and re-arm for the next one.
        acc_d       = {ACC_W{1'b0}};
        first_d     = 1'b1;
        beat_cnt_d  = 16'd0;
        sat_d       = 1'b0;
        out_valid_d = 1'b1;
        out_data_d  = act_s;
        acc_sat_d   = sat_q | clamp_s;
        grp_len_d   = beat_cnt_q + 16'd1;
      end else begin
        acc_d       = sum_sat_s[ACC_W-1:0];
        first_d     = 1'b0;
        beat_cnt_d  = beat_cnt_q + 16'd1;
        sat_d       = sat_q | clamp_s;
        // A beat is only accepted when the output is empty or draining.
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q && !out_ready;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q       <= {ACC_W{1'b0}};
      first_q     <= 1'b1;
      beat_cnt_q  <= 16'd0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {OUT_W{1'b0}};
      acc_sat_q   <= 1'b0;
      grp_len_q   <= 16'd0;
    end else begin
      acc_q       <= acc_d;
      first_q     <= first_d;
      beat_cnt_q  <= beat_cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      acc_sat_q   <= acc_sat_d;
      grp_len_q   <= grp_len_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign acc_sat   = acc_sat_q;
  assign grp_len   = grp_len_q;

endmodule

// File: tb/tb_cnn_conv_acc_relu.sv
// ---------------------------------------------------------------------------
// Testbench for cnn_conv_acc_relu. Two instances (ReLU on / off) share one
// stimulus stream. A reference model computes each group's result with plain
// 64-bit arithmetic and pushes it to a per-instance queue; a monitor compares
// whatever each instance presents against the queue head.
// ---------------------------------------------------------------------------
module tb_cnn_conv_acc_relu;

  localparam longint AMAX = (longint'(1) <<< 31) - 1;
  localparam longint AMIN = -(longint'(1) <<< 31);
  localparam longint OMAX = 8191;
  localparam longint OMIN = -8192;

  logic        ap_clk;
  logic        ap_rst_n;
  logic        prod_valid;
  logic [23:0] prod_data;
  logic        prod_last;
  logic [13:0] bias;
  logic        out_ready;

  logic        prod_ready_r, out_valid_r, acc_sat_r;
  logic [13:0] out_data_r;
  logic [15:0] grp_len_r;
  logic        prod_ready_l, out_valid_l, acc_sat_l;
  logic [13:0] out_data_l;
  logic [15:0] grp_len_l;

  cnn_conv_acc_relu #(.RELU_EN(1'b1)) dut_relu (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .prod_valid(prod_valid), .prod_ready(prod_ready_r),
    .prod_data(prod_data), .prod_last(prod_last), .bias(bias),
    .out_valid(out_valid_r), .out_ready(out_ready),
    .out_data(out_data_r), .acc_sat(acc_sat_r), .grp_len(grp_len_r)
  );

  cnn_conv_acc_relu #(.RELU_EN(1'b0)) dut_lin (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .prod_valid(prod_valid), .prod_ready(prod_ready_l),
    .prod_data(prod_data), .prod_last(prod_last), .bias(bias),
    .out_valid(out_valid_l), .out_ready(out_ready),
    .out_data(out_data_l), .acc_sat(acc_sat_l), .grp_len(grp_len_l)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct packed {
    logic [13:0] d;
    logic        sat;
    logic [15:0] len;
  } exp_t;

  exp_t   q_r[$];
  exp_t   q_l[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  int     rdy_mode = 0;

  // Reference model state: running saturated sum of the open group.
  longint m_acc;
  bit     m_first;
  int     m_cnt;
  bit     m_sat;

  // cycle counter
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_acc   = 0;
    m_first = 1'b1;
    m_cnt   = 0;
    m_sat   = 1'b0;
  endfunction

  function automatic longint clamp_out(input longint v);
    if (v > OMAX) return OMAX;
    if (v < OMIN) return OMIN;
    return v;
  endfunction

  task automatic model_accept(input longint d, input longint b, input bit last);
    longint s, r, r_lin, r_relu;
    exp_t   e;
    if (m_first) s = b * 256 + d;
    else         s = m_acc + d;
    if (s > AMAX) begin s = AMAX; m_sat = 1'b1; end
    else if (s < AMIN) begin s = AMIN; m_sat = 1'b1; end
    m_acc   = s;
    m_first = 1'b0;
    m_cnt++;
    if (last) begin
      r      = (s + 128) >>> 8;
      r_lin  = clamp_out(r);
      r_relu = (r < 0) ? 0 : clamp_out(r);
      e.sat  = m_sat;
      e.len  = m_cnt[15:0];
      e.d    = r_relu[13:0];
      q_r.push_back(e);
      e.d    = r_lin[13:0];
      q_l.push_back(e);
      model_reset();
    end
  endtask

  // Drive one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input longint d, input longint b, input bit last);
    bit ok;
    int n;
    prod_valid = 1'b1;
    prod_data  = d[23:0];
    bias       = b[13:0];
    prod_last  = last;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 500) begin
      @(negedge ap_clk);
      ok = prod_ready_r;
      @(posedge ap_clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: beat %0d not accepted in 500 cycles", d);
    end else begin
      model_accept(d, b, last);
      if (last) begin
        chk("latency_relu", out_valid_r, 1);
        chk("latency_lin", out_valid_l, 1);
      end
    end
  endtask

  task automatic idle(input int n);
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    repeat (n) @(posedge ap_clk);
    #1;
  endtask

  // out_ready driver: 0 = always ready, 1 = stalled, other = random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge ap_clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'b0;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare presented results against queue heads; pop on handshake.
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (out_valid_r) begin
        if (q_r.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_relu: data %0d", $signed(out_data_r));
        end else begin
          chk("data_relu", $signed(out_data_r), $signed(q_r[0].d));
          chk("sat_relu", acc_sat_r, q_r[0].sat);
          chk("len_relu", grp_len_r, q_r[0].len);
          if (!out_ready) chk("stall_ready_relu", prod_ready_r, 0);
          else void'(q_r.pop_front());
        end
      end
      if (out_valid_l) begin
        if (q_l.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_lin: data %0d", $signed(out_data_l));
        end else begin
          chk("data_lin", $signed(out_data_l), $signed(q_l[0].d));
          chk("sat_lin", acc_sat_l, q_l[0].sat);
          chk("len_lin", grp_len_l, q_l[0].len);
          if (!out_ready) chk("stall_ready_lin", prod_ready_l, 0);
          else void'(q_l.pop_front());
        end
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid_relu"}, out_valid_r, 0);
    chk({tag, "_data_relu"}, out_data_r, 0);
    chk({tag, "_sat_relu"}, acc_sat_r, 0);
    chk({tag, "_len_relu"}, grp_len_r, 0);
    chk({tag, "_valid_lin"}, out_valid_l, 0);
    chk({tag, "_data_lin"}, out_data_l, 0);
    chk({tag, "_sat_lin"}, acc_sat_l, 0);
    chk({tag, "_len_lin"}, grp_len_l, 0);
  endtask

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint t0;
    logic [23:0] rv;
    logic [13:0] rb;
    int glen;

    prod_valid = 1'b0;
    prod_data  = 24'd0;
    prod_last  = 1'b0;
    bias       = 14'd0;
    ap_rst_n   = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge ap_clk);
    #1;
    chk_zero_outputs("reset");
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("reset_prod_ready", prod_ready_r, 1);

    // Bias pre-load and three-beat group
    send_beat(256, 1, 1'b0);
    send_beat(512, 1, 1'b0);
    send_beat(768, 1, 1'b1);
    idle(2);

    // Rounding cases
    send_beat(384, 0, 1'b1);
    send_beat(383, 0, 1'b1);
    send_beat(-384, 0, 1'b1);
    idle(2);

    // ReLU and negative output clamp (bias drives it below -8192)
    send_beat(-1000000, 0, 1'b1);
    send_beat(-1000000, -8192, 1'b1);
    idle(2);

    // Accumulator saturation, then a clean single-beat group
    for (int i = 0; i < 300; i++) send_beat(8388607, 0, i == 299);
    send_beat(256, 0, 1'b1);
    idle(2);

    // Backpressure: result held for 5 cycles while the next group waits
    rdy_mode = 1;
    send_beat(1000, 3, 1'b1);
    fork
      begin
        send_beat(-5000, 7, 1'b0);
        send_beat(70000, 7, 1'b0);
        send_beat(12345, 7, 1'b1);
      end
      begin
        repeat (5) @(posedge ap_clk);
        #2;
        rdy_mode = 0;
      end
    join
    idle(3);

    // Back-to-back single-beat groups: one result per cycle
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      rv = 24'($urandom);
      rb = 14'($urandom);
      send_beat(longint'($signed(rv)), longint'($signed(rb)), 1'b1);
    end
    chk("throughput_cycles", cyc - t0, 8);
    idle(3);

    // Randomised groups under random backpressure
    rdy_mode = 2;
    for (int g = 0; g < 40; g++) begin
      glen = $urandom_range(1, 6);
      rb = 14'($urandom);
      for (int k = 0; k < glen; k++) begin
        rv = 24'($urandom);
        send_beat(longint'($signed(rv)), longint'($signed(rb)), k == glen - 1);
      end
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_mode = 0;
    idle(10);

    // Reset in the middle of a group discards it
    send_beat(100, 0, 1'b0);
    send_beat(200, 0, 1'b0);
    ap_rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    q_r.delete();
    q_l.delete();
    model_reset();
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    @(negedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    send_beat(512, 0, 1'b1);
    idle(4);

    chk("queue_empty_relu", q_r.size(), 0);
    chk("queue_empty_lin", q_l.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
